// File: rtl/ram_readout_seq_pkg.sv
// ram_readout_seq_pkg: shared state encoding for the ILA read-out sequencer
package ram_readout_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_LOAD, S_ACTIVE} state_e;
endpackage

// File: rtl/ring_addr_ctr.sv
// ring_addr_ctr: wrapping BRAM address counter with load and increment
module ring_addr_ctr #(
  parameter int addr_width = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  inc_i,
  input  logic [addr_width-1:0] val_i,
  output logic [addr_width-1:0] addr_o
);
  logic [addr_width-1:0] addr_q, addr_d;
  always_comb addr_d = load_i ? val_i : inc_i ? addr_q + addr_width'(1) : addr_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) addr_q <= '0;
    else addr_q <= addr_d;
  assign addr_o = addr_q;
endmodule

// File: rtl/ram_readout_seq.sv
// ram_readout_seq: walks the circular capture buffer oldest-to-newest, one sample per read pulse
module ram_readout_seq
  import ram_readout_seq_pkg::*;
#(
  parameter int sample_width = 24,
  parameter int addr_width   = 10
) (
  input  logic                    i_clk_ILA,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [addr_width-1:0]   i_wr_ptr,
  input  logic [addr_width:0]     i_sample_count,
  input  logic                    i_rd,
  input  logic [sample_width-1:0] i_ram_data,
  output logic [addr_width-1:0]   o_ram_addr,
  output logic                    o_ram_en,
  output logic [sample_width-1:0] o_sample,
  output logic                    o_read_active,
  output logic                    o_busy,
  output logic                    o_done
);
  state_e state_q, state_d;
  logic [addr_width:0] rem_q, rem_d;
  logic [sample_width-1:0] sample_q, sample_d;
  logic en_q, en_d, act_q, act_d, done_q, done_d, rl_q, rl_d;
  logic start_ok, rd_ok, last, ld, inc;
  logic [addr_width-1:0] start_addr;
  assign start_ok   = state_q == S_IDLE && i_start;
  assign rd_ok      = state_q == S_ACTIVE && i_rd;
  assign last       = rd_ok && rem_q == (addr_width+1)'(1);
  assign ld         = !i_abort && start_ok && i_sample_count != '0;
  assign inc        = !i_abort && rd_ok && rem_q > (addr_width+1)'(1);
  // a full buffer truncates the count to zero, so the walk starts at the write pointer
  assign start_addr = i_wr_ptr - i_sample_count[addr_width-1:0];
  ring_addr_ctr #(.addr_width(addr_width)) u_addr (
    .clk_i (i_clk_ILA),
    .rst_i (i_reset),
    .load_i(ld),
    .inc_i (inc),
    .val_i (start_addr),
    .addr_o(o_ram_addr)
  );
  always_ff @(posedge i_clk_ILA or posedge i_reset)
    if (i_reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      sample_q <= '0;
      en_q     <= 1'b0;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
      rl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      sample_q <= sample_d;
      en_q     <= en_d;
      act_q    <= act_d;
      done_q   <= done_d;
      rl_q     <= rl_d;
    end
  always_comb
    state_d = i_abort ? S_IDLE
      : state_q == S_IDLE  ? (ld ? S_PRIME : S_IDLE)
      : state_q == S_PRIME ? S_LOAD
      : state_q == S_LOAD  ? S_ACTIVE
      : last ? S_IDLE : S_ACTIVE;
  // rl_q marks the cycle when BRAM data for an in-run reload is on i_ram_data
  always_comb begin
    en_d     = ld || inc;
    rl_d     = !i_abort && en_q && state_q == S_ACTIVE;
    rem_d    = i_abort ? rem_q : ld ? i_sample_count : rd_ok ? rem_q - (addr_width+1)'(1) : rem_q;
    done_d   = !i_abort && (last || (start_ok && i_sample_count == '0));
    act_d    = i_abort ? 1'b0 : state_q == S_LOAD ? 1'b1 : last ? 1'b0 : act_q;
    sample_d = !i_abort && (state_q == S_LOAD || rl_q) ? i_ram_data : sample_q;
  end
  assign o_ram_en      = en_q;
  assign o_sample      = sample_q;
  assign o_read_active = act_q;
  assign o_busy        = state_q != S_IDLE;
  assign o_done        = done_q;
endmodule
